// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: speed divider, free run, single-instruction step and
// PC breakpoint, with address/data snapshot taken on every halt.
module cpu_step_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [2:0]        speed_sel,
  input  logic              run_mode,
  input  logic              step_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              cpu_m1,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ce,
  output logic              halted,
  output logic              bp_hit,
  output logic [ADDR_W-1:0] snap_addr,
  output logic [DATA_W-1:0] snap_data,
  output logic [CNT_W-1:0]  step_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        div_cnt_q, div_cnt_d;
  logic              m1_q, m1_d;
  logic              moved_q, moved_d;
  logic              step_q, step_d;
  logic              halted_q, halted_d;
  logic              bp_hit_q, bp_hit_d;
  logic [ADDR_W-1:0] snap_addr_q, snap_addr_d;
  logic [DATA_W-1:0] snap_data_q, snap_data_d;
  logic [CNT_W-1:0]  step_count_q, step_count_d;

  logic tick, boundary, bp_match, stop_cond, stop, ce;

  always_comb begin
    tick      = (div_cnt_q >= speed_sel);
    div_cnt_d = tick ? 3'd0 : div_cnt_q + 3'd1;
    boundary  = cpu_m1 & ~m1_q;
    bp_match  = bp_en & (cpu_addr == bp_addr);
    stop_cond = (state_q == ST_STEP) ? 1'b1 : (~run_mode | bp_match);
    // moved gates stop so the first instruction after a halt always gets clocked
    stop      = moved_q & boundary & stop_cond;
    ce        = tick & (state_q != ST_HALT) & ~stop & ~reset;

    state_d      = state_q;
    bp_hit_d     = bp_hit_q;
    step_count_d = step_count_q;
    snap_addr_d  = snap_addr_q;
    snap_data_d  = snap_data_q;
    moved_d      = moved_q;
    m1_d         = ce ? cpu_m1 : m1_q;
    step_d       = step_req;

    case (state_q)
      ST_RUN: begin
        if (tick && stop) begin
          state_d = ST_HALT;
          if (bp_match) bp_hit_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (run_mode) begin
          state_d  = ST_RUN;
          bp_hit_d = 1'b0;
        end else if (step_req && !step_q) begin
          state_d  = ST_STEP;
          bp_hit_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (tick && stop) begin
          state_d      = ST_HALT;
          step_count_d = step_count_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if ((state_q != ST_HALT) && (state_d == ST_HALT)) begin
      snap_addr_d = cpu_addr;
      snap_data_d = cpu_data;
      moved_d     = 1'b0;
    end else if (ce) begin
      moved_d = 1'b1;
    end

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_RUN;
      div_cnt_q    <= 3'd0;
      m1_q         <= 1'b0;
      moved_q      <= 1'b0;
      step_q       <= 1'b1;
      halted_q     <= 1'b0;
      bp_hit_q     <= 1'b0;
      snap_addr_q  <= '0;
      snap_data_q  <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      m1_q         <= m1_d;
      moved_q      <= moved_d;
      step_q       <= step_d;
      halted_q     <= halted_d;
      bp_hit_q     <= bp_hit_d;
      snap_addr_q  <= snap_addr_d;
      snap_data_q  <= snap_data_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_ce     = ce;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;
  assign snap_addr  = snap_addr_q;
  assign snap_data  = snap_data_q;
  assign step_count = step_count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Sequences the Z80 core in the Rememotech MiSTer build through one CPU clock-enable.
- Implements the OSD CPU-speed divider (25.000 down to 3.125 MHz from the 25 MHz domain), free run, single-instruction step and a PC breakpoint.
- On every halt it freezes the address and data bus into snapshot registers, which feed the debug-overlay probe lines.

Parameters:
- ADDR_W, 16: CPU address width; also the width of bp_addr and snap_addr.
- DATA_W, 8: CPU data width; also the width of snap_data.
- CNT_W, 16: width of step_count.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- speed_sel  in  3  divide ratio minus 1 (0 → ce every cycle, 7 → every 8th cycle); OSD O57.
- run_mode  in  1  1 = free run, 0 = stepped/halted.
- step_req  in  1  level from OSD trigger; each rising edge requests one instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint fetch address.
- cpu_m1  in  1  CPU M1 (opcode fetch) status, active high, reflects current T-state.
- cpu_addr  in  ADDR_W  CPU address bus.
- cpu_data  in  DATA_W  CPU data bus.
- cpu_ce  out  1  CPU clock enable; one pulse = one T-state.
- halted  out  1  1 while in HALT.
- bp_hit  out  1  sticky; set on breakpoint halt.
- snap_addr  out  ADDR_W  cpu_addr captured on halt entry.
- snap_data  out  DATA_W  cpu_data captured on halt entry.
- step_count  out  CNT_W  completed single steps.

Behaviour:
- Reset values (synchronous, highest priority):
  - state=RUN, div_cnt=0, m1_q=0, moved=0.
  - cpu_ce=0, halted=0, bp_hit=0, snap_addr=0, snap_data=0, step_count=0.
  - step_q=1, so a step_req held high through reset does not produce a step.
- Divider:
  - tick = (div_cnt >= speed_sel).
  - On tick, div_cnt←0; otherwise div_cnt←div_cnt+1.
  - The divider free-runs in all states.
  - A speed_sel decrease below div_cnt yields an immediate tick; no lock-up.
- Boundary: boundary = cpu_m1 & ~m1_q.
  - m1_q←cpu_m1 on every cycle where cpu_ce=1.
  - A true boundary means the CPU has entered a new instruction's fetch and has not yet been clocked.
- cpu_ce (combinational, Mealy) = tick & (state∈{RUN,STEP}) & ~stop.
  - stop = moved & boundary & stop_cond.
  - moved is set on the first cpu_ce after leaving HALT and cleared on HALT entry.
  - This guarantees progress out of a halt at a boundary.
- stop_cond:
  - In STEP: 1.
  - In RUN: run_mode=0, or (bp_en & cpu_addr==bp_addr).
- States:
  - RUN:
    - Issues ce on each tick.
    - On tick & stop → HALT.
    - If the halt is caused by the breakpoint (bp_en & address match), bp_hit←1.
    - If run_mode and the breakpoint are both true on the same cycle, bp_hit←1.
    - step edges are ignored in RUN.
  - HALT:
    - No ce.
    - run_mode=1 → RUN.
    - Else a step_req rising edge (step_req & ~step_q) → STEP.
    - Leaving HALT clears bp_hit.
  - STEP:
    - Issues ce on each tick until tick & stop, then → HALT.
    - On that transition step_count←step_count+1, wrapping from 2^CNT_W−1 to 0.
    - Changes to run_mode during STEP are ignored until HALT; HALT then moves to RUN on the next cycle if run_mode=1.
    - Additional step edges during STEP are dropped (not queued).
- Halt entry (any source):
  - halted←1 on the following cycle.
  - snap_addr←cpu_addr and snap_data←cpu_data are sampled on the transition cycle.
- step_q←step_req every cycle.
- Reset asserted mid-STEP or mid-RUN:
  - The step is abandoned and no count increments.
  - cpu_ce is 0 during the reset cycle.

Test Plan:
- Reset, run_mode=1, speed_sel=3 → cpu_ce high exactly 1 of every 4 cycles; speed_sel=0 → cpu_ce every cycle; halted=0.
- Model CPU with 4-T fetch at addr 0x1000/0x1001; run_mode 1→0 → halts at next boundary; halted=1, snap_addr=0x1001, snap_data=bus value, cpu_ce stays 0.
- From HALT, pulse step_req (held 10 cycles) → exactly one instruction of ce pulses, halt at next boundary, step_count 0→1; the long pulse does not cause a second step.
- run_mode=1, bp_en=1, bp_addr=0x0038 → halt with snap_addr=0x0038, bp_hit=1; step from there → bp_hit clears, advances past 0x0038 without re-halting immediately.
- step_count preloaded to 0xFFFF via 65535 steps, or via a bench force → next step gives 0x0000.
- reset asserted mid-STEP with step_req held high → state RUN, step_count unchanged, no spurious step after reset release.
